// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: controller state
// encoding and the datapath word width.
package mul_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_A = 3'd1,
        S_WAIT_B = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// Watchdog iteration counter: counts ld_p pulses and flags when the count
// has reached the configured iteration limit.
module mul_iter_cnt #(
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] MAX_ITER = {CNT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max
);

    logic [CNT_W-1:0] r_count;

    // Clear wins over increment; increment is never requested at the limit,
    // so the counter saturates without an explicit clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_ITER);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Control FSM for the repeated-addition multiplier: accepts two operand beats,
// then adds A into P once per count of B, bounded by a watchdog.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int               CNT_W    = 16,
    parameter logic [CNT_W-1:0] MAX_ITER = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             eqz,
    output logic             ld_a,
    output logic             ld_b,
    output logic             clr_p,
    output logic             ld_p,
    output logic             dec_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    state_t r_state;
    state_t w_fsm_next;
    state_t w_next;
    logic   r_err;
    logic   w_at_max;
    logic   w_start_acc;
    logic   w_run_step;
    logic   w_wd_fire;

    // An abort in the same cycle as start leaves err and the counter untouched.
    assign w_start_acc = (r_state == S_IDLE) && start && !abort;
    assign w_run_step  = !eqz && !w_at_max;
    assign w_wd_fire   = (r_state == S_RUN) && !eqz && w_at_max && !abort;

    mul_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_acc),
        .i_inc    (ld_p),
        .o_count  (iter_count),
        .o_at_max (w_at_max)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; eqz is checked before the watchdog limit.
    always_comb begin
        w_fsm_next = r_state;
        case (r_state)
            S_IDLE:   w_fsm_next = start      ? S_WAIT_A : S_IDLE;
            S_WAIT_A: w_fsm_next = data_valid ? S_WAIT_B : S_WAIT_A;
            S_WAIT_B: w_fsm_next = data_valid ? S_RUN    : S_WAIT_B;
            S_RUN:    w_fsm_next = (eqz || w_at_max) ? S_DONE : S_RUN;
            S_DONE:   w_fsm_next = S_IDLE;
            default:  w_fsm_next = S_IDLE;
        endcase
        w_next = abort ? S_IDLE : w_fsm_next;
    end

    // Datapath strobes decoded from state; still driven during an abort cycle.
    always_comb begin
        data_ready = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        clr_p      = 1'b0;
        ld_p       = 1'b0;
        dec_b      = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_WAIT_A: begin
                data_ready = 1'b1;
                ld_a       = data_valid;
            end
            S_WAIT_B: begin
                data_ready = 1'b1;
                ld_b       = data_valid;
                clr_p      = data_valid;
            end
            S_RUN: begin
                ld_p  = w_run_step;
                dec_b = w_run_step;
            end
            S_DONE:  done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    // Sticky watchdog flag, cleared only when a new multiply is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_wd_fire) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err  = r_err;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural A/B/P datapath model;
// a second instance with a tiny iteration limit exercises the watchdog.
module tb_mul_seq_ctrl;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, data_valid = 1'b0, start_w = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic data_ready, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, err, eqz;
    logic [15:0] iter_count;
    logic data_ready_w, ld_a_w, ld_b_w, clr_p_w, ld_p_w, dec_b_w, busy_w, done_w, err_w;
    logic [15:0] iter_w;
    logic [15:0] ra = '0, rb = '0, rp = '0;

    typedef struct {
        int          done_cyc;
        logic [15:0] prod;
        logic [15:0] iter;
        logic        err;
        int          nldp;
    } exp_t;

    exp_t q[$];
    exp_t qw[$];
    exp_t e, ew;
    int cyc = 0, n_cmp = 0, n_bad = 0, ldp_n = 0, ldp_nw = 0, t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .data_valid(data_valid),
        .data_ready(data_ready), .eqz(eqz), .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p),
        .ld_p(ld_p), .dec_b(dec_b), .busy(busy), .done(done), .err(err),
        .iter_count(iter_count)
    );

    mul_seq_ctrl #(.CNT_W(16), .MAX_ITER(16'd4)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .abort(1'b0), .data_valid(data_valid),
        .data_ready(data_ready_w), .eqz(1'b0), .ld_a(ld_a_w), .ld_b(ld_b_w),
        .clr_p(clr_p_w), .ld_p(ld_p_w), .dec_b(dec_b_w), .busy(busy_w), .done(done_w),
        .err(err_w), .iter_count(iter_w)
    );

    // Datapath model driven by the controller strobes.
    always @(posedge clk) begin
        if (ld_a) ra <= data;
        if (ld_b) rb <= data;
        else if (dec_b) rb <= rb - 16'd1;
        if (clr_p) rp <= 16'd0;
        else if (ld_p) rp <= rp + ra;
    end
    assign eqz = (rb == 16'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor for the main instance.
    always @(negedge clk) begin
        if (ld_b) ldp_n = 0;
        else if (ld_p) ldp_n++;
        if ((ld_a || ld_b || clr_p) && !data_valid) chk("strobe_without_valid", 1, 0);
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("product", rp, e.prod);
                chk("iter_count", iter_count, e.iter);
                chk("err", err, e.err);
                chk("ld_p_pulses", ldp_n, e.nldp);
            end
        end
    end

    // Monitor for the watchdog instance.
    always @(negedge clk) begin
        if (ld_b_w) ldp_nw = 0;
        else if (ld_p_w) ldp_nw++;
        if (done_w) begin
            if (qw.size() == 0) begin
                chk("wd_unexpected_done", 1, 0);
            end else begin
                ew = qw.pop_front();
                chk("wd_done_cycle", cyc, ew.done_cyc);
                chk("wd_iter_count", iter_w, ew.iter);
                chk("wd_err", err_w, ew.err);
                chk("wd_ld_p_pulses", ldp_nw, ew.nldp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            #1 chk("gap_strobes_ready", {ld_a, ld_b, clr_p, data_ready}, 4'b0001);
            tick();
        end
    endtask

    task automatic beat(input logic [15:0] v, input bit is_a);
        data_valid = 1'b1;
        data = v;
        #1;
        if (is_a) chk("beat_a_strobes", {ld_a, ld_b, clr_p, data_ready}, 4'b1001);
        else      chk("beat_b_strobes", {ld_a, ld_b, clr_p, data_ready}, 4'b0111);
        tick();
        data_valid = 1'b0;
        data = '0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (busy && k < lim) begin
            tick();
            k++;
        end
        chk("op_finishes", busy, 0);
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int ga, input int gb);
        start = 1'b1;
        q.push_back('{cyc + 4 + int'(b) + ga + gb, 16'(a * b), b, 1'b0, int'(b)});
        tick();
        start = 1'b0;
        gap(ga);
        beat(a, 1'b1);
        gap(gb);
        beat(b, 1'b0);
        // Stray beat during RUN must be ignored.
        data_valid = 1'b1;
        data = 16'hBEEF;
        #1 chk("run_ignores_valid", {data_ready, ld_a, ld_b, clr_p}, 4'b0000);
        tick();
        data_valid = 1'b0;
        data = '0;
        wait_idle(200);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        tick();
        chk("reset_outputs", {busy, done, err, ld_a, ld_b, clr_p, ld_p, dec_b, data_ready}, 9'd0);
        chk("reset_iter", iter_count, 0);
        rst = 1'b0;
        tick();

        run_mul(16'd17, 16'd5, 0, 0);
        run_mul(16'd9, 16'd0, 0, 0);
        run_mul(16'd3, 16'd6, 3, 2);

        // Watchdog: limit 4 with eqz stuck low.
        repeat (2) begin
            start_w = 1'b1;
            qw.push_back('{cyc + 8, 16'd0, 16'd4, 1'b1, 4});
            tick();
            start_w = 1'b0;
            #1 chk("wd_err_clear_on_start", {err_w, busy_w}, 2'b01);
            data_valid = 1'b1;
            data = 16'd5;
            #1 chk("wd_ld_a", ld_a_w, 1);
            tick();
            #1 chk("wd_ld_b", {ld_b_w, clr_p_w}, 2'b11);
            tick();
            data_valid = 1'b0;
            repeat (10) tick();
            chk("wd_idle", busy_w, 0);
        end

        // Abort on the third RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        beat(16'd7, 1'b1);
        beat(16'd10, 1'b0);
        tick();
        tick();
        abort = 1'b1;
        #1 chk("abort_cycle_ld_p", {ld_p, dec_b}, 2'b11);
        tick();
        abort = 1'b0;
        #1 chk("after_abort_busy", busy, 0);
        chk("after_abort_iter", iter_count, 3);
        chk("after_abort_err", err, 0);
        repeat (3) tick();

        // Start held throughout; DONE must not accept it, the next IDLE must.
        start = 1'b1;
        t0 = cyc;
        q.push_back('{t0 + 7, 16'd6, 16'd3, 1'b0, 3});
        tick();
        beat(16'd2, 1'b1);
        beat(16'd3, 1'b0);
        while (cyc < t0 + 8) tick();
        chk("no_start_in_done", busy, 0);
        q.push_back('{cyc + 8, 16'd20, 16'd4, 1'b0, 4});
        tick();
        start = 1'b0;
        beat(16'd5, 1'b1);
        beat(16'd4, 1'b0);
        wait_idle(200);

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        beat(16'd7, 1'b1);
        beat(16'd9, 1'b0);
        tick();
        #3 chk("run_before_rst", ld_p, 1);
        rst = 1'b1;
        #1 chk("async_rst_outputs", {busy, ld_p, dec_b, done, data_ready, err}, 6'd0);
        chk("async_rst_iter", iter_count, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        chk("queues_drained", q.size() + qw.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Control-path FSM for the repeated-addition multiplier: P = A × B, computed by adding A into P, B times.
It sequences the datapath register loads for the A and B operand registers and the P accumulator, the P clear, and the B decrement. Operands arrive as two beats on the shared 16-bit data bus under a valid/ready handshake.
A watchdog iteration counter bounds runtime and flags an error if the zero-detect (eqz) never asserts.

Parameters:
CNT_W, 16, width of iteration counter and iter_count output
MAX_ITER, 16'hFFFF, ld_p pulses allowed before watchdog abort; must be >= 1 and < 2**CNT_W

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a multiply; sampled in IDLE only
abort  input  1  synchronous abort; returns to IDLE from any state
data_valid  input  1  operand beat present on shared bus
data_ready  output  1  controller accepts a beat this cycle
eqz  input  1  datapath B-register == 0 (comparator output)
ld_a  output  1  load A register from bus
ld_b  output  1  load B register from bus
clr_p  output  1  clear P accumulator
ld_p  output  1  load P <= P + A
dec_b  output  1  B <= B - 1
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  watchdog fired on last operation; sticky until next accepted start
iter_count  output  CNT_W  ld_p pulses issued in current/last operation

Behaviour:
States: IDLE, WAIT_A, WAIT_B, RUN, DONE.
- IDLE:
  - start=1 -> WAIT_A.
  - Same edge: clear iter_count and err.
- WAIT_A:
  - data_ready=1.
  - ld_a = data_valid (combinational, same cycle as the beat).
  - data_valid -> WAIT_B; otherwise stay (gaps allowed).
- WAIT_B:
  - data_ready=1.
  - ld_b = clr_p = data_valid.
  - data_valid -> RUN.
- RUN, evaluated each cycle:
  - eqz=1 -> DONE, with no ld_p/dec_b that cycle.
  - Otherwise, if iter_count == MAX_ITER -> DONE with err<=1, no ld_p/dec_b.
  - Otherwise ld_p=1, dec_b=1, iter_count++, stay in RUN.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE unconditionally.
  - P holds the result from this cycle onward.
- Output decoding:
  - ld_a, ld_b, clr_p, ld_p, dec_b, data_ready and done are decoded from state (plus data_valid/eqz as noted).
  - All are 0 in IDLE.
- Latency: with contiguous beats and start sampled at edge 0, ld_p is high cycles 3..(2+B) and done at cycle 4+B. B=0 gives done at cycle 4.
- abort:
  - Highest priority after rst: next state IDLE from any state.
  - No done, err unchanged, iter_count holds.
  - Outputs that depend on state are still driven in the abort cycle.
- start while busy: ignored, no queueing. A start coincident with the DONE cycle is also ignored.
- data_valid outside WAIT_A/WAIT_B: ignored; data_ready=0.
- rst asserted (async, any time, including mid-RUN):
  - state=IDLE, iter_count=0, err=0, busy=0, done=0.
  - All load/clear/decrement strobes 0 immediately.
- Arithmetic:
  - iter_count is unsigned, saturating by construction via the MAX_ITER check; it never wraps.
  - The eqz check has priority over the watchdog in the same cycle.

Decomposition:
- Shared package mul_pkg:
  - state encoding localparams (3-bit: IDLE=0, WAIT_A=1, WAIT_B=2, RUN=3, DONE=4)
  - DATA_W=16 constant, shared with the datapath registers
- One natural sub-module: mul_iter_cnt.
  - CNT_W-bit counter with clear, increment and terminal-compare (== MAX_ITER) output.
  - Async reset.

Test Plan:
- A=17, B=5, start at edge 0, beats at cycles 1,2 -> ld_a@1, ld_b+clr_p@2, ld_p/dec_b high cycles 3–7, done@9, iter_count=5, err=0. Bench datapath model holds P=85.
- A=9, B=0 -> no ld_p, done@4, P=0, iter_count=0.
- MAX_ITER=4, eqz tied 0 after operand load -> exactly 4 ld_p pulses, then done pulse with err=1, iter_count=4. Next start clears err.
- A=3, B=6:
  - Insert 3 idle cycles between start and beat A, and 2 between the beats -> ld strobes align with data_valid only, and data_ready is low outside WAIT_A/WAIT_B.
  - Product 18.
- abort asserted on the 3rd RUN cycle of B=10 -> IDLE next cycle, no done, iter_count=3, busy=0.
- rst pulsed asynchronously (mid-cycle) during RUN -> all strobes and busy drop before the next clock edge.
- start held high throughout the operation -> exactly one multiply before DONE, no start acceptance in the DONE cycle, and a new operation is accepted in the following IDLE cycle.
